// File: rtl/sccb_table_sequencer.sv
// rtl/sccb_table_sequencer.sv - table-driven SCCB register loader; optional readback verify via SCCB_VERIFY_EN
module sccb_table_sequencer #(
  parameter logic [7:0] DEV_ID     = 8'h42,
  parameter int         TBL_AW     = 6,
  parameter int         DELAY_UNIT = 100,
  parameter int         RETRY_MAX  = 2
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              go,
  input  logic              mid_pulse,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              eng_start,
  output logic              eng_rw,
  output logic [7:0]        eng_id_addr,
  output logic [7:0]        eng_sub_addr,
  output logic [7:0]        eng_data_in,
  input  logic [7:0]        eng_data_out,
  input  logic              eng_done,
  output logic              busy,
  output logic              cfg_done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index
);

  // Wide enough for 8'hFF * DELAY_UNIT without overflow.
  localparam int DLY_W = 8 + $clog2(DELAY_UNIT) + 1;
  localparam logic [TBL_AW-1:0] ADDR_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DELAY, S_NEXT, S_DONE, S_FAIL
`ifdef SCCB_VERIFY_EN
    , S_VRD_ISSUE, S_VRD_WAIT, S_CHECK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic [7:0]        sub_q, data_q, id_q;
  logic              rw_q;
  logic [DLY_W-1:0]  dly_q;
  logic              cfg_done_q, error_q;
  logic [7:0]        tbl_sub;

  assign tbl_sub = tbl_data[15:8];

`ifdef SCCB_VERIFY_EN
  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY_MAX);

  logic [RTY_W-1:0]  retry_q;
  logic              rd_phase_q;   // the GAP being served follows a readback
  logic [7:0]        rd_data_q;
  logic [TBL_AW-1:0] err_index_q;
  logic              skip_verify;
  logic              rd_match;

  // A soft reset write reboots the sensor, so its register cannot be read back.
  assign skip_verify = (sub_q == 8'h12) && data_q[7];
  assign rd_match    = (rd_data_q == data_q);
  assign err_index   = err_index_q;
`else
  logic unused_sink;
  assign unused_sink = (^eng_data_out) ^ (RETRY_MAX != 0);
  assign err_index   = '0;
`endif

  assign tbl_addr     = tbl_addr_q;
  assign eng_rw       = rw_q;
  assign eng_id_addr  = id_q;
  assign eng_sub_addr = sub_q;
  assign eng_data_in  = data_q;
  assign cfg_done     = cfg_done_q;
  assign error        = error_q;

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: only leaving IDLE ignores mid_pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_FETCH;
      S_FETCH: if (mid_pulse) begin
        if (tbl_sub == 8'hFF)      state_d = S_DONE;
        else if (tbl_sub == 8'hFE) state_d = S_DELAY;
        else                       state_d = S_ISSUE;
      end
      S_ISSUE: if (mid_pulse) state_d = S_WAIT;
      S_WAIT:  if (mid_pulse && eng_done) state_d = S_GAP;
      S_GAP:   if (mid_pulse) begin
`ifdef SCCB_VERIFY_EN
        if (rd_phase_q)       state_d = S_CHECK;
        else if (skip_verify) state_d = S_NEXT;
        else                  state_d = S_VRD_ISSUE;
`else
        state_d = S_NEXT;
`endif
      end
      S_DELAY: if (mid_pulse && (dly_q <= DLY_W'(1))) state_d = S_NEXT;
      S_NEXT:  if (mid_pulse) state_d = (tbl_addr_q == ADDR_MAX) ? S_DONE : S_FETCH;
      S_DONE:  if (mid_pulse) state_d = S_IDLE;
      S_FAIL:  if (mid_pulse) state_d = S_IDLE;
`ifdef SCCB_VERIFY_EN
      S_VRD_ISSUE: if (mid_pulse) state_d = S_VRD_WAIT;
      S_VRD_WAIT:  if (mid_pulse && eng_done) state_d = S_GAP;
      S_CHECK:     if (mid_pulse) begin
        if (rd_match)                 state_d = S_NEXT;
        else if (retry_q == RTY_LAST) state_d = S_FAIL;
        else                          state_d = S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: start covers issue+wait, busy is anything but idle.
  always_comb begin
    eng_start = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_ISSUE, S_WAIT: eng_start = 1'b1;
`ifdef SCCB_VERIFY_EN
      S_VRD_ISSUE, S_VRD_WAIT: eng_start = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath: table index, latched entry, delay count, sticky status.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      tbl_addr_q  <= '0;
      sub_q       <= '0;
      data_q      <= '0;
      id_q        <= '0;
      rw_q        <= 1'b0;
      dly_q       <= '0;
      cfg_done_q  <= 1'b0;
      error_q     <= 1'b0;
`ifdef SCCB_VERIFY_EN
      retry_q     <= '0;
      rd_phase_q  <= 1'b0;
      rd_data_q   <= '0;
      err_index_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          tbl_addr_q <= '0;
          cfg_done_q <= 1'b0;
          error_q    <= 1'b0;
`ifdef SCCB_VERIFY_EN
          retry_q    <= '0;
          rd_phase_q <= 1'b0;
`endif
        end
        S_FETCH: if (mid_pulse) begin
          if (tbl_sub == 8'hFE) begin
            dly_q <= DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
          end else if (tbl_sub != 8'hFF) begin
            sub_q  <= tbl_sub;
            data_q <= tbl_data[7:0];
            id_q   <= DEV_ID;
            rw_q   <= 1'b0;
          end
        end
        S_DELAY: if (mid_pulse && (dly_q != '0)) dly_q <= dly_q - DLY_W'(1);
        S_NEXT: if (mid_pulse) begin
          if (tbl_addr_q != ADDR_MAX) tbl_addr_q <= tbl_addr_q + TBL_AW'(1);
`ifdef SCCB_VERIFY_EN
          retry_q <= '0;
`endif
        end
        S_DONE: if (mid_pulse) cfg_done_q <= 1'b1;
        S_FAIL: if (mid_pulse) begin
          error_q <= 1'b1;
`ifdef SCCB_VERIFY_EN
          err_index_q <= tbl_addr_q;
`endif
        end
`ifdef SCCB_VERIFY_EN
        S_GAP: if (mid_pulse) begin
          if (rd_phase_q) begin
            rd_phase_q <= 1'b0;
          end else if (!skip_verify) begin
            rw_q <= 1'b1;
            id_q <= DEV_ID | 8'h01;
          end
        end
        S_VRD_WAIT: if (mid_pulse && eng_done) begin
          rd_data_q  <= eng_data_out;
          rd_phase_q <= 1'b1;
        end
        S_CHECK: if (mid_pulse && !rd_match && (retry_q != RTY_LAST)) begin
          retry_q <= retry_q + RTY_W'(1);
          rw_q    <= 1'b0;
          id_q    <= DEV_ID;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
